// File: rtl/parser_pkg.sv
// Shared message types and SRAM geometry for the parser/sequencer blocks.
package parser_pkg;

    localparam int unsigned SRAM_ADDR_W = 14;
    localparam int unsigned SRAM_DEPTH  = 16384;
    localparam int unsigned WORD_CNT_W  = 15;
    localparam int unsigned DIM_W       = 16;
    localparam int unsigned DATA_W      = 32;

    typedef enum logic [3:0] {
        MSG_NONE           = 4'd0,
        MSG_CFG_IMG        = 4'd1,
        MSG_START_BURST_WR = 4'd2,
        MSG_START_BURST_RD = 4'd3,
        MSG_ERR            = 4'd15
    } msg_type_e;

endpackage

// File: rtl/msg_pulse_det.sv
// Rising-edge detector for the classifier's level-type valid signal.
module msg_pulse_det (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic pulse_c
);

    logic sig_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sig_q <= 1'b0;
        else        sig_q <= sig;
    end

    assign pulse_c = sig & ~sig_q;

endmodule

// File: rtl/seq_tx_image_burst.sv
// Burst read-back sequencer: streams RGB SRAM words to the TX message builder.
module seq_tx_image_burst
    import parser_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  msg_type_e              Msg_Type,
    input  logic                   new_msg_valid,
    input  logic [DIM_W-1:0]       img_height,
    input  logic [DIM_W-1:0]       img_width,
    input  logic [DATA_W-1:0]      red_rd_data,
    input  logic [DATA_W-1:0]      green_rd_data,
    input  logic [DATA_W-1:0]      blue_rd_data,
    input  logic                   tx_ready,
    output logic                   sram_r_rd_en,
    output logic                   sram_g_rd_en,
    output logic                   sram_b_rd_en,
    output logic [SRAM_ADDR_W-1:0] sram_r_addr_rd,
    output logic [SRAM_ADDR_W-1:0] sram_g_addr_rd,
    output logic [SRAM_ADDR_W-1:0] sram_b_addr_rd,
    output logic [DATA_W-1:0]      tx_red_burst,
    output logic [DATA_W-1:0]      tx_green_burst,
    output logic [DATA_W-1:0]      tx_blue_burst,
    output logic                   tx_valid,
    output logic                   tx_seq_burst_busy,
    output logic                   tx_seq_burst_dn,
    output logic                   got_msg_from_class
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        CLASS_HS = 4'd1,
        READ     = 4'd2,
        CAPTURE  = 4'd3,
        SEND     = 4'd4,
        CHECK    = 4'd5,
        CMPLTD   = 4'd6
    } state_e;

    state_e                 state_q, state_d;
    logic [WORD_CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic [DIM_W-1:0]       h_q, h_d, w_q, w_d;
    logic [DATA_W-1:0]      r_q, r_d, g_q, g_d, b_q, b_d;
    logic                   rd_en_q, rd_en_d;
    logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic                   dn_q, dn_d;
    logic                   got_q, got_d;
    logic                   msg_pulse_c;
    logic                   start_c;
    logic [31:0]            words_c;
    logic [WORD_CNT_W-1:0]  max_words_c;

    msg_pulse_det u_msg_pulse_det (
        .clk     (clk),
        .rst_n   (rst_n),
        .sig     (new_msg_valid),
        .pulse_c (msg_pulse_c)
    );

    assign start_c = msg_pulse_c && (Msg_Type == MSG_START_BURST_RD);

    // Partial final word is dropped; transfer length never exceeds SRAM depth.
    assign words_c     = (32'(h_q) * 32'(w_q)) >> 2;
    assign max_words_c = (words_c > 32'(SRAM_DEPTH)) ? WORD_CNT_W'(SRAM_DEPTH)
                                                     : WORD_CNT_W'(words_c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            word_cnt_q <= '0;
            h_q        <= '0;
            w_q        <= '0;
            r_q        <= '0;
            g_q        <= '0;
            b_q        <= '0;
            rd_en_q    <= 1'b0;
            addr_q     <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            dn_q       <= 1'b0;
            got_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            h_q        <= h_d;
            w_q        <= w_d;
            r_q        <= r_d;
            g_q        <= g_d;
            b_q        <= b_d;
            rd_en_q    <= rd_en_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            dn_q       <= dn_d;
            got_q      <= got_d;
        end
    end

    // Outputs are decoded from the next state so the registered copies line up with the state.
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        h_d        = h_q;
        w_d        = w_q;
        r_d        = r_q;
        g_d        = g_q;
        b_d        = b_q;

        case (state_q)
            IDLE: begin
                word_cnt_d = '0;
                if (start_c) begin
                    state_d = CLASS_HS;
                    h_d     = img_height;
                    w_d     = img_width;
                end
            end
            CLASS_HS: state_d = (max_words_c == '0) ? CMPLTD : READ;
            READ:     state_d = CAPTURE;
            CAPTURE: begin
                r_d     = red_rd_data;
                g_d     = green_rd_data;
                b_d     = blue_rd_data;
                state_d = SEND;
            end
            SEND: begin
                if (tx_ready) begin
                    word_cnt_d = word_cnt_q + WORD_CNT_W'(1);
                    state_d    = CHECK;
                end
            end
            CHECK:    state_d = (word_cnt_q < max_words_c) ? READ : CMPLTD;
            CMPLTD:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        rd_en_d = (state_d == READ);
        addr_d  = rd_en_d ? word_cnt_d[SRAM_ADDR_W-1:0] : '0;
        valid_d = (state_d == SEND);
        busy_d  = (state_d == CLASS_HS) || (state_d == READ) || (state_d == CAPTURE)
               || (state_d == SEND) || (state_d == CHECK);
        dn_d    = (state_d == CMPLTD);
        got_d   = (state_d == CLASS_HS);
    end

    assign sram_r_rd_en       = rd_en_q;
    assign sram_g_rd_en       = rd_en_q;
    assign sram_b_rd_en       = rd_en_q;
    assign sram_r_addr_rd     = addr_q;
    assign sram_g_addr_rd     = addr_q;
    assign sram_b_addr_rd     = addr_q;
    assign tx_red_burst       = r_q;
    assign tx_green_burst     = g_q;
    assign tx_blue_burst      = b_q;
    assign tx_valid           = valid_q;
    assign tx_seq_burst_busy  = busy_q;
    assign tx_seq_burst_dn    = dn_q;
    assign got_msg_from_class = got_q;

endmodule

// File: tb/tb_seq_tx_image_burst.sv
// Randomized bench: SRAM model plus a word-list reference for seq_tx_image_burst.
module tb_seq_tx_image_burst;
    import parser_pkg::*;

    logic                   clk;
    logic                   rst_n;
    msg_type_e              Msg_Type;
    logic                   new_msg_valid;
    logic [DIM_W-1:0]       img_height, img_width;
    logic [DATA_W-1:0]      red_rd_data, green_rd_data, blue_rd_data;
    logic                   tx_ready;
    logic                   sram_r_rd_en, sram_g_rd_en, sram_b_rd_en;
    logic [SRAM_ADDR_W-1:0] sram_r_addr_rd, sram_g_addr_rd, sram_b_addr_rd;
    logic [DATA_W-1:0]      tx_red_burst, tx_green_burst, tx_blue_burst;
    logic                   tx_valid, tx_seq_burst_busy, tx_seq_burst_dn, got_msg_from_class;

    logic [DATA_W-1:0] r_mem [SRAM_DEPTH];
    logic [DATA_W-1:0] g_mem [SRAM_DEPTH];
    logic [DATA_W-1:0] b_mem [SRAM_DEPTH];

    int errors = 0;
    int checks = 0;

    seq_tx_image_burst dut (
        .clk(clk), .rst_n(rst_n), .Msg_Type(Msg_Type), .new_msg_valid(new_msg_valid),
        .img_height(img_height), .img_width(img_width),
        .red_rd_data(red_rd_data), .green_rd_data(green_rd_data), .blue_rd_data(blue_rd_data),
        .tx_ready(tx_ready),
        .sram_r_rd_en(sram_r_rd_en), .sram_g_rd_en(sram_g_rd_en), .sram_b_rd_en(sram_b_rd_en),
        .sram_r_addr_rd(sram_r_addr_rd), .sram_g_addr_rd(sram_g_addr_rd),
        .sram_b_addr_rd(sram_b_addr_rd),
        .tx_red_burst(tx_red_burst), .tx_green_burst(tx_green_burst),
        .tx_blue_burst(tx_blue_burst),
        .tx_valid(tx_valid), .tx_seq_burst_busy(tx_seq_burst_busy),
        .tx_seq_burst_dn(tx_seq_burst_dn), .got_msg_from_class(got_msg_from_class)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read SRAM model, one per channel.
    always @(posedge clk) begin
        if (sram_r_rd_en) red_rd_data   <= r_mem[sram_r_addr_rd];
        if (sram_g_rd_en) green_rd_data <= g_mem[sram_g_addr_rd];
        if (sram_b_rd_en) blue_rd_data  <= b_mem[sram_b_addr_rd];
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_strobes"}, {sram_r_rd_en, sram_g_rd_en, sram_b_rd_en,
                                sram_r_addr_rd, sram_g_addr_rd, sram_b_addr_rd}, '0);
        chk({tag, "_payload"}, {tx_red_burst, tx_green_burst, tx_blue_burst}, '0);
        chk({tag, "_flags"}, {tx_valid, tx_seq_burst_busy, tx_seq_burst_dn,
                              got_msg_from_class}, '0);
    endtask

    // One start message; the expected stream is memory words 0..max-1 in order.
    task automatic run_burst(input int h, input int w, input int stall_word, input int stall_len,
                             input int hold, input int restart_cyc, input int rst_at_word,
                             input bit rand_ready);
        longint prod;
        int max, rd_i, hs_i, got_n, dn_n, cyc, first_v, stall_cnt, budget;
        bit done, prev_hold, hs;
        logic [95:0] prev_pl;

        prod = longint'(h) * longint'(w);
        max  = int'(prod >> 2);
        if (max > int'(SRAM_DEPTH)) max = int'(SRAM_DEPTH);
        budget = max * 16 + 100;
        rd_i = 0; hs_i = 0; got_n = 0; dn_n = 0; cyc = 0; first_v = -1; stall_cnt = 0;
        done = 0; prev_hold = 0; prev_pl = '0;

        @(negedge clk);
        Msg_Type      = MSG_START_BURST_RD;
        img_height    = DIM_W'(h);
        img_width     = DIM_W'(w);
        new_msg_valid = 1'b1;

        while (!done && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (cyc == hold) new_msg_valid = 1'b0;
            if (restart_cyc > 0 && cyc == restart_cyc) new_msg_valid = 1'b1;
            if (restart_cyc > 0 && cyc == restart_cyc + 2) new_msg_valid = 1'b0;

            if (rst_at_word >= 0 && hs_i == rst_at_word && tx_valid) begin
                rst_n = 1'b0;
                new_msg_valid = 1'b0;
                #1;
                chk_all_zero("rst_mid");
                @(negedge clk);
                chk_all_zero("rst_hold");
                rst_n = 1'b1;
                return;
            end

            chk("rd_en_match", {sram_g_rd_en, sram_b_rd_en}, {sram_r_rd_en, sram_r_rd_en});
            if (sram_r_rd_en) begin
                chk("rd_addr", {sram_r_addr_rd, sram_g_addr_rd, sram_b_addr_rd},
                    {SRAM_ADDR_W'(rd_i), SRAM_ADDR_W'(rd_i), SRAM_ADDR_W'(rd_i)});
                rd_i++;
            end else begin
                chk("addr_idle", sram_r_addr_rd, '0);
            end
            if (got_msg_from_class) got_n++;
            if (tx_valid && first_v < 0) first_v = cyc;

            if (prev_hold) begin
                chk("valid_hold", tx_valid, 1'b1);
                chk("payload_hold", {tx_red_burst, tx_green_burst, tx_blue_burst}, prev_pl);
            end

            if (tx_valid && hs_i == stall_word && stall_cnt < stall_len) begin
                tx_ready = 1'b0;
                stall_cnt++;
            end else begin
                tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            hs = tx_valid && tx_ready;

            if (hs) begin
                if (hs_i < max)
                    chk("payload", {tx_red_burst, tx_green_burst, tx_blue_burst},
                        {r_mem[hs_i], g_mem[hs_i], b_mem[hs_i]});
                else
                    chk("extra_word", hs_i, max);
                hs_i++;
            end
            if (tx_seq_burst_dn) begin
                dn_n++;
                chk("dn_after_last", hs_i, max);
                chk("dn_not_busy", tx_seq_burst_busy, 1'b0);
                done = 1;
            end
            prev_hold = tx_valid && !hs;
            prev_pl   = {tx_red_burst, tx_green_burst, tx_blue_burst};
        end

        if (!done) chk("timeout", 1'b0, 1'b1);
        chk("words_sent", hs_i, max);
        chk("words_read", rd_i, max);
        chk("got_once", got_n, 1);
        if (max > 0) chk("first_valid_latency", first_v, 4);
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_idle", {tx_valid, tx_seq_burst_busy, tx_seq_burst_dn,
                              got_msg_from_class, sram_r_rd_en}, '0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        Msg_Type = MSG_NONE;
        new_msg_valid = 1'b0;
        img_height = '0;
        img_width = '0;
        tx_ready = 1'b0;
        red_rd_data = '0;
        green_rd_data = '0;
        blue_rd_data = '0;
        for (int i = 0; i < int'(SRAM_DEPTH); i++) begin
            r_mem[i] = $urandom;
            g_mem[i] = $urandom;
            b_mem[i] = $urandom;
        end
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_all_zero("after_reset");

        // Non-start message type must not launch a transfer.
        Msg_Type = MSG_START_BURST_WR;
        new_msg_valid = 1'b1;
        repeat (2) @(negedge clk);
        new_msg_valid = 1'b0;
        chk("wrong_type", {tx_seq_burst_busy, got_msg_from_class}, '0);

        run_burst(4, 4, -1, 0, 1, 0, -1, 0);
        run_burst(2, 4, 0, 10, 1, 0, -1, 0);
        run_burst(0, 0, -1, 0, 1, 0, -1, 0);
        run_burst(1, 3, -1, 0, 1, 0, -1, 0);
        for (int k = 0; k < 5; k++)
            run_burst(int'($urandom_range(0, 12)), int'($urandom_range(0, 12)),
                      -1, 0, 1, 0, -1, 1);
        run_burst(4, 8, -1, 0, 3, 12, -1, 1);
        run_burst(8, 8, -1, 0, 1, 0, 5, 0);
        run_burst(4, 4, -1, 0, 1, 0, -1, 1);
        run_burst(256, 256, -1, 0, 1, 0, -1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_tx_image_burst.md
# seq_tx_image_burst

Burst read-back sequencer, the transmit-direction counterpart of the RX burst image writer. On a `MSG_START_BURST_RD` message from the classifier, it reads the R, G and B SRAMs one 32-bit word (4 packed pixels) at a time. It then hands each RGB word triple to the UART message transmitter through a valid/ready handshake until `(height*width)/4` words have been sent. It sits between the parser/classifier CDC outputs, the three channel SRAM read ports, and the TX message builder.

## Interface
- No parameters. SRAM depth is fixed at 16384 words (14-bit address).
- `clk` in 1: system clock. One clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `Msg_Type` in `msg_type_e`: classified message type.
- `new_msg_valid` in 1: classifier data available. Level signal; may stay high for several cycles.
- `img_height` in 16: image height, sampled on start.
- `img_width` in 16: image width, sampled on start.
- `red_rd_data` in 32: R SRAM read data, valid 1 cycle after `sram_r_rd_en`.
- `green_rd_data` in 32: G SRAM read data, same timing.
- `blue_rd_data` in 32: B SRAM read data, same timing.
- `tx_ready` in 1: transmitter accepts the current word when high together with `tx_valid`.
- `sram_r_rd_en`, `sram_g_rd_en`, `sram_b_rd_en` out 1 each: read strobes, all identical.
- `sram_r_addr_rd`, `sram_g_addr_rd`, `sram_b_addr_rd` out 14 each: read address, all identical.
- `tx_red_burst`, `tx_green_burst`, `tx_blue_burst` out 32 each: registered word payload.
- `tx_valid` out 1: payload valid.
- `tx_seq_burst_busy` out 1: transfer in progress.
- `tx_seq_burst_dn` out 1: one-cycle done pulse.
- `got_msg_from_class` out 1: acknowledge to the classifier.

## Operation
- Start detection:
  - Rising edge of `new_msg_valid`, detected with a one-flop delay, gives a one-cycle pulse.
  - A pulse with `Msg_Type==MSG_START_BURST_RD` while in IDLE is a start.
  - Pulses seen in any other state are ignored.
- On start, latch `img_height` and `img_width`.
- `max_words = (32'(h)*32'(w))>>2` in 32-bit arithmetic; a partial final word (h*w not a multiple of 4) is dropped.
- `word_cnt` is 15 bits, cleared in IDLE. Address = `word_cnt[13:0]`. `max_words` is clamped to 16384.
- States:
  - IDLE → CLASS_HS on start.
  - CLASS_HS: `got_msg_from_class=1`, busy=1. If `max_words==0` go to CMPLTD, else go to READ.
  - READ: `rd_en=1` on all three SRAMs, addr=`word_cnt` → CAPTURE.
  - CAPTURE: register the three read-data buses into the payload registers → SEND.
  - SEND: `tx_valid=1`, payload held stable. Stay until `tx_ready=1`. On handshake, `word_cnt++` → CHECK.
  - CHECK: if `word_cnt<max_words` go to READ, else go to CMPLTD.
  - CMPLTD: `tx_seq_burst_dn=1`, busy=0 → IDLE.
  - Illegal encoding → IDLE.
- Defaults in every state other than those above: `rd_en=0`, `addr=0`, `tx_valid=0`, `dn=0`, `got_msg_from_class=0`. Busy=1 in CLASS_HS through CHECK.
- Payload registers keep their last value outside CAPTURE.

## Timing
- Reset values: all strobes, `tx_valid`, busy, dn and `got_msg_from_class` are 0. Addresses, payloads, `word_cnt`, the latched dimensions and the edge-detect flop are 0. State is IDLE.
- `new_msg_valid` rising at edge T (start) → CLASS_HS in cycle T+1 → READ T+2 → CAPTURE T+3 → first `tx_valid` T+4.
- Per word, minimum 4 cycles (READ, CAPTURE, SEND, CHECK) when `tx_ready` is already high.
- `tx_valid` never drops without a handshake. The payload does not change while `tx_valid=1`.
- `tx_ready` high outside SEND has no effect.
- Reset asserted mid-transfer: immediate return to IDLE, all outputs to their reset values. A new start is required afterwards.
- A start pulse coincident with CMPLTD is ignored; the host resends.

## Structure
- `parser_pkg`: add `MSG_START_BURST_RD` to `msg_type_e`, and define the shared constants `SRAM_ADDR_W=14` and `SRAM_DEPTH=16384`.
- State enum stays local to the module, as `typedef enum logic [3:0]`.
- One natural sub-module: `msg_pulse_det` (rising-edge detector on `new_msg_valid`), shareable with the RX sequencers.

## Test plan
- 4x4 start with `tx_ready` tied high → reads at addresses 0..3. Four handshakes carry the SRAM contents in address order. `dn` pulses once, and only after the 4th handshake.
- 2x4 start with `tx_ready` low for 10 cycles on word 0 → `tx_valid` stays high and the payload is constant across the stall. Exactly 2 words are sent, at addresses 0 and 1.
- 0x0 and 1x3 starts → no `rd_en`. `got_msg_from_class` is high for one cycle, then a `dn` pulse, then back to IDLE.
- 256x256 start → 16384 words. Last address is 16383, `word_cnt` reaches 16384, there is no wrap, and `dn` follows.
- `new_msg_valid` held high for 3 cycles, then a second start mid-transfer → exactly one transfer runs and the second start is ignored.
- `rst_n` pulsed low during SEND of word 5 of 16 → all outputs are 0 immediately. A fresh 4x4 start afterwards restarts at address 0.
